// File: rtl/md_unit.sv
// HI/LO multiply/divide unit: mult/multu/div/divu plus mthi/mtlo register writes.
// MD_MULTI_CYCLE_EN selects 5/10-cycle latency with busy; undefined gives single-cycle results.
module md_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        write_HI,
    input  logic        write_LO,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    // Returns {HI, LO}. Division works on magnitudes so 0x80000000 / -1 needs no special case.
    function automatic logic [63:0] md_calc(input logic [1:0] f_op,
                                            input logic [31:0] f_a,
                                            input logic [31:0] f_b);
        logic [63:0] ext_a;
        logic [63:0] ext_b;
        logic [63:0] prod;
        logic        neg_a;
        logic        neg_b;
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] quo;
        logic [31:0] rem;
        ext_a = f_op[0] ? {32'd0, f_a} : {{32{f_a[31]}}, f_a};
        ext_b = f_op[0] ? {32'd0, f_b} : {{32{f_b[31]}}, f_b};
        prod  = ext_a * ext_b;
        neg_a = !f_op[0] && f_a[31];
        neg_b = !f_op[0] && f_b[31];
        mag_a = neg_a ? (32'd0 - f_a) : f_a;
        mag_b = neg_b ? (32'd0 - f_b) : f_b;
        quo   = (mag_b == 32'd0) ? 32'd0 : mag_a / mag_b;
        rem   = (mag_b == 32'd0) ? 32'd0 : mag_a % mag_b;
        if (neg_a ^ neg_b) quo = 32'd0 - quo;
        if (neg_a)         rem = 32'd0 - rem;
        return f_op[1] ? {rem, quo} : prod;
    endfunction

    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;

    assign HI = hi_reg;
    assign LO = lo_reg;

`ifdef MD_MULTI_CYCLE_EN
    logic [3:0]  count_reg, count_next;
    logic [31:0] a_reg, a_next;
    logic [31:0] b_reg, b_next;
    logic [1:0]  op_reg, op_next;
    logic        busy_reg;
    logic [63:0] result;
    logic        div_zero;

    assign result   = md_calc(op_reg, a_reg, b_reg);
    assign div_zero = op_reg[1] && (b_reg == 32'd0);
    assign busy     = busy_reg;

    always_comb begin
        count_next = count_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        op_next    = op_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        if (count_reg == 4'd0) begin
            if (start) begin
                a_next     = A;
                b_next     = B;
                op_next    = op;
                count_next = op[1] ? 4'd10 : 4'd5;
            end else begin
                if (write_HI) hi_next = A;
                if (write_LO) lo_next = A;
            end
        end else begin
            // Commit on the 1->0 step; a zero divisor still burns the full latency.
            count_next = count_reg - 4'd1;
            if (count_reg == 4'd1 && !div_zero) begin
                hi_next = result[63:32];
                lo_next = result[31:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= 4'd0;
            a_reg     <= 32'd0;
            b_reg     <= 32'd0;
            op_reg    <= 2'd0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
            busy_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            op_reg    <= op_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            busy_reg  <= (count_next != 4'd0);
        end
    end
`else
    logic [63:0] result;
    logic        div_zero;

    assign result   = md_calc(op, A, B);
    assign div_zero = op[1] && (B == 32'd0);
    assign busy     = 1'b0;

    always_comb begin
        hi_next = hi_reg;
        lo_next = lo_reg;
        if (start) begin
            if (!div_zero) begin
                hi_next = result[63:32];
                lo_next = result[31:0];
            end
        end else begin
            if (write_HI) hi_next = A;
            if (write_LO) lo_next = A;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_reg <= 32'd0;
            lo_reg <= 32'd0;
        end else begin
            hi_reg <= hi_next;
            lo_reg <= lo_next;
        end
    end
`endif

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: vector table, hand-written corner sequences and
// randomized operations against a longint arithmetic reference model.
module tb_md_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        write_HI = 1'b0;
    logic        write_LO = 1'b0;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int failures = 0;
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    md_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .write_HI(write_HI), .write_LO(write_LO), .busy(busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    function automatic int latency(input logic [1:0] o);
`ifdef MD_MULTI_CYCLE_EN
        return o[1] ? 10 : 5;
`else
        return 0;
`endif
    endfunction

    // Reference: plain 64-bit arithmetic; SV longint division truncates toward zero.
    task automatic model_apply(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, q, r;
        sa = o[0] ? longint'({32'd0, a}) : longint'($signed(a));
        sb = o[0] ? longint'({32'd0, b}) : longint'($signed(b));
        if (!o[1]) begin
            p = sa * sb;
            hi_m = p[63:32];
            lo_m = p[31:0];
        end else if (b != 32'd0) begin
            q = sa / sb;
            r = sa % sb;
            hi_m = r[31:0];
            lo_m = q[31:0];
        end
    endtask

    // Launch at a negedge; returns at the first negedge where results should be visible.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic wr);
        int n;
        logic [31:0] old_hi;
        old_hi = hi_m;
        start = 1'b1; op = o; A = a; B = b; write_HI = wr; write_LO = wr;
        @(negedge clk);
        start = 1'b0; write_HI = 1'b0; write_LO = 1'b0;
        A = $urandom; B = $urandom;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            if (n == 0) check("hi_held_during_run", HI, old_hi);
            n++;
            @(negedge clk);
        end
        check("busy_cycles", n, latency(o));
        model_apply(o, a, b);
        check("HI", HI, hi_m);
        check("LO", LO, lo_m);
        $display("op=%0d A=%08h B=%08h -> HI=%08h LO=%08h busy_cycles=%0d", o, a, b, HI, LO, n);
    endtask

    task automatic do_write(input logic wh, input logic wl, input logic [31:0] a);
        write_HI = wh; write_LO = wl; A = a;
        @(negedge clk);
        write_HI = 1'b0; write_LO = 1'b0;
        if (wh) hi_m = a;
        if (wl) lo_m = a;
        check("mt_HI", HI, hi_m);
        check("mt_LO", LO, lo_m);
        $display("write HI=%0b LO=%0b A=%08h -> HI=%08h LO=%08h", wh, wl, a, HI, LO);
    endtask

    initial begin
        vecs[0] = '{2'd0, 32'hFFFFFFFF, 32'd2,          32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1] = '{2'd1, 32'hFFFFFFFF, 32'd2,          32'h00000001, 32'hFFFFFFFE};
        vecs[2] = '{2'd2, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{2'd3, 32'd7,        32'd2,          32'd1,        32'd3};
        vecs[4] = '{2'd2, 32'h80000000, 32'hFFFFFFFF,   32'd0,        32'h80000000};
        vecs[5] = '{2'd0, 32'h80000000, 32'h80000000,   32'h40000000, 32'd0};
        vecs[6] = '{2'd3, 32'hFFFFFFFF, 32'd16,         32'h0000000F, 32'h0FFFFFFF};
        vecs[7] = '{2'd2, 32'd7,        32'hFFFFFFFE,   32'd1,        32'hFFFFFFFD};

        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_HI", HI, 32'd0);
        check("reset_LO", LO, 32'd0);

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
            check("vec_HI", HI, vecs[i].hi);
            check("vec_LO", LO, vecs[i].lo);
        end

        // Divide by zero leaves preloaded HI and existing LO intact.
        do_write(1'b1, 1'b0, 32'h00001234);
        do_op(2'd2, 32'd99, 32'd0, 1'b0);
        check("div0_HI", HI, 32'h00001234);
        check("div0_LO", LO, 32'hFFFFFFFD);

        do_write(1'b1, 1'b1, 32'hCAFEF00D);

        // start and writes together: start wins.
        do_op(2'd1, 32'd6, 32'd7, 1'b1);
        check("start_wins_HI", HI, 32'd0);
        check("start_wins_LO", LO, 32'd42);

`ifdef MD_MULTI_CYCLE_EN
        begin
            int n;
            start = 1'b1; op = 2'd0; A = 32'd3; B = 32'd5;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            start = 1'b1; op = 2'd2; A = 32'h0000AAAA; B = 32'd1; write_LO = 1'b1; write_HI = 1'b1;
            @(negedge clk);
            start = 1'b0; write_LO = 1'b0; write_HI = 1'b0;
            n = 0;
            while (busy === 1'b1 && n < 20) begin
                n++;
                @(negedge clk);
            end
            check("ignored_remaining_cycles", n, 32'd3);
            model_apply(2'd0, 32'd3, 32'd5);
            check("ignored_HI", HI, hi_m);
            check("ignored_LO", LO, lo_m);
            @(negedge clk);
            check("no_relaunch_busy", {31'd0, busy}, 32'd0);
            $display("busy-ignore sequence -> HI=%08h LO=%08h", HI, LO);
        end
`endif

        for (int i = 0; i < 30; i++) begin
            logic [1:0]  o;
            logic [31:0] a, b;
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 9));
                2: b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) do_write(1'($urandom), 1'($urandom), $urandom);
            do_op(o, a, b, 1'($urandom));
        end

        // Reset in the middle of a divide aborts it for good.
        start = 1'b1; op = 2'd3; A = 32'd100; B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        hi_m = 32'd0;
        lo_m = 32'd0;
        for (int c = 0; c < 12; c++) begin
            check("abort_busy", {31'd0, busy}, 32'd0);
            check("abort_HI", HI, 32'd0);
            check("abort_LO", LO, 32'd0);
            @(negedge clk);
        end
        $display("reset abort -> HI=%08h LO=%08h busy=%0b", HI, LO, busy);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL provide port: start  input  1  launch multiply/divide this cycle (driven by ALU_mult/ALU_div decode).
REQ-004 SHALL provide port: op  input  2  00 mult, 01 multu, 10 div, 11 divu.
REQ-005 SHALL provide port: A  input  32  operand rs (multiplicand / dividend).
REQ-006 SHALL provide port: B  input  32  operand rt (multiplier / divisor).
REQ-007 SHALL provide port: write_HI  input  1  mthi, HI <= A.
REQ-008 SHALL provide port: write_LO  input  1  mtlo, LO <= A.
REQ-009 SHALL provide port: busy  output  1  operation in flight; upstream stalls mfhi/mflo/mult/div while high.
REQ-010 SHALL provide port: HI  output  32  registered HI value.
REQ-011 SHALL provide port: LO  output  32  registered LO value.
REQ-012 Clocking SHALL be one clock (clk); reset SHALL be synchronous and active-high (reset).

Function
REQ-013 SHALL hold state IDLE (counter=0) and RUN (counter>0); busy = (counter != 0), registered.
REQ-014 In IDLE, start=1 at edge T0 SHALL latch A, B and op, load counter with 5 (mult/multu) or 10 (div/divu), and enter RUN.
REQ-015 Counter SHALL decrement once per edge in RUN; at the edge where counter goes 1->0, HI/LO SHALL update and busy SHALL fall, so results are visible after edge T0+N and busy is high for exactly N cycles.
REQ-016 mult SHALL form the signed 64-bit product; multu the unsigned one; HI = product[63:32], LO = product[31:0].
REQ-017 div SHALL give LO = signed quotient truncated toward zero and HI = remainder with the dividend's sign; divu SHALL do the unsigned equivalents.
REQ-018 Divisor 0 SHALL run the full 10-cycle latency and leave HI and LO unchanged.
REQ-019 div 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-020 start while busy=1 SHALL be ignored (no relaunch, no operand change).
REQ-021 write_HI/write_LO while busy=1 SHALL be ignored.
REQ-022 In IDLE, start and write_HI/write_LO in the same cycle: start SHALL win and the writes are dropped.
REQ-023 write_HI and write_LO together in IDLE SHALL both load A.
REQ-024 HI/LO SHALL always output the registered values, including old values during RUN; there is no bypass of in-flight results.
REQ-025 Results SHALL depend only on the operands latched at T0, not on A/B during RUN.

Reset
REQ-026 reset=1 at an edge SHALL clear HI, LO, counter and latched operands to 0, and busy to 0, overriding all other inputs.
REQ-027 reset mid-operation SHALL abort it; HI/LO SHALL be 0 and SHALL NOT later take the aborted result.

Configuration
REQ-028 Macro MD_MULTI_CYCLE_EN SHALL select the latency model.
REQ-029 With MD_MULTI_CYCLE_EN defined, behaviour SHALL follow REQ-013..REQ-025 (5/10-cycle latency, busy active).
REQ-030 Without MD_MULTI_CYCLE_EN, start SHALL write HI/LO at edge T0 itself (results visible next cycle), busy SHALL be constant 0, and REQ-020/REQ-021 do not apply; all arithmetic rules are unchanged.

Verification
REQ-031 mult A=0xFFFFFFFF B=2 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-032 div A=-7 (0xFFFFFFF9) B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7 B=2 -> LO=3, HI=1.
REQ-033 Preload HI=0x1234 via mthi, then div with B=0 -> after 10 cycles HI=0x1234 and LO unchanged.
REQ-034 Start mult; in cycle 2 assert start(div) with write_LO A=0xAAAA -> both ignored; result equals the original mult only.
REQ-035 Start div; assert reset in cycle 4 -> next cycle busy=0, HI=LO=0, and they stay 0 through cycle 12.
REQ-036 IDLE: start plus write_HI in the same cycle -> HI ends as the product, not A; repeat REQ-031 with MD_MULTI_CYCLE_EN undefined -> results one cycle after start, busy never 1.
